// File: rtl/jtgng_rom_arb.sv
// Fixed-priority arbiter from SLOTS ROM clients onto one SDRAM read port, one buffered word per slot.
// Define JTGNG_ROMARB_HOLD_EN to keep a slot's buffered word valid while its slot_cs is low.
module jtgng_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic                  loop_rst,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*DW-1:0]   slot_dout,
    output logic                  sdram_req,
    output logic [AW-1:0]         sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [DW-1:0]         data_read,
    output logic                  refresh_en
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] WAIT_RDY = 2'd2;
    localparam int CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    cur;
    logic [CW-1:0]    win_idx;
    logic [AW-1:0]    win_addr;
    logic             win_vld;
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] miss;
    logic [AW-1:0]    tag  [SLOTS];
    logic [DW-1:0]    rbuf [SLOTS];
    logic             abort;

    assign abort = downloading | loop_rst;

    always_comb begin
        for (int n = 0; n < SLOTS; n++) begin
            slot_ok[n]               = slot_cs[n] & valid[n] & (tag[n] == slot_addr[n*AW +: AW]);
            slot_dout[n*DW +: DW]    = rbuf[n];
        end
    end

    assign miss       = slot_cs & ~slot_ok;
    assign refresh_en = (state == IDLE) & ~|miss;

    // Scan from the top so the lowest-index miss overwrites the others.
    always_comb begin
        win_vld  = |miss;
        win_idx  = '0;
        win_addr = '0;
        for (int n = SLOTS-1; n >= 0; n--) begin
            if (miss[n]) begin
                win_idx  = CW'(n);
                win_addr = slot_addr[n*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            cur        <= '0;
            valid      <= '0;
            for (int n = 0; n < SLOTS; n++) begin
                tag[n]  <= '0;
                rbuf[n] <= '0;
            end
        end else if (abort) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cur        <= win_idx;
                        sdram_addr <= win_addr;
                        sdram_req  <= 1'b1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    // Tag comes from the latched request address, not the slot's current one.
                    if (data_rdy) begin
                        rbuf[cur]  <= data_read;
                        tag[cur]   <= sdram_addr;
                        valid[cur] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef JTGNG_ROMARB_HOLD_EN
            // Buffered words stay valid across cs deassertion.
`else
            // Placed after the case so a deasserted cs wins over a same-cycle fill.
            for (int n = 0; n < SLOTS; n++) begin
                if (!slot_cs[n]) valid[n] <= 1'b0;
            end
`endif
        end
    end
endmodule
